nibble_serial_add: RTL and testbench



---
 rtl/nibble_serial_add.sv | 157 +++++++++++++++
 tb/tb_nibble_serial_add.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add.sv
// rtl/nibble_serial_add.sv - wide adder built from one 4-bit slice, one nibble per clock
// Optional signed-overflow flag `ovf` is built only when SIGNED_OVF_EN is defined.

module carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_add #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WORDS-1:0] a,
  input  logic [4*WORDS-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [4*WORDS-1:0] sum,
  output logic               cout
`ifdef SIGNED_OVF_EN
  ,
  output logic               ovf
`endif
);
  localparam int W  = 4 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
`ifdef SIGNED_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic            accept;
  logic            last;
  logic [IW+1:0]   base;
  logic [3:0]      slice_a;
  logic [3:0]      slice_b;
  logic [3:0]      slice_sum;
  logic            slice_cout;

  // start is only honoured outside RUN; DONE doubles as the restart slot
  assign accept  = start && (state_q != S_RUN);
  assign last    = (state_q == S_RUN) && (idx_q == IW'(WORDS - 1));
  assign base    = {idx_q, 2'b00};
  assign slice_a = a_q[base +: 4];
  assign slice_b = b_q[base +: 4];

  carry_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      sum_d[base +: 4] = slice_sum;
      carry_d          = slice_cout;
      if (last) begin
        cout_d = slice_cout;
`ifdef SIGNED_OVF_EN
        ovf_d  = (a_q[W-1] == b_q[W-1]) && (slice_sum[3] != a_q[W-1]);
`endif
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add.sv
// tb/tb_nibble_serial_add.sv - random and directed bench for nibble_serial_add
// Builds with or without SIGNED_OVF_EN.

module tb_nibble_serial_add;
  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_add #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lowmask(input int n);
    logic [W-1:0] ones;
    ones = '1;
    return ones >> (W - 4 * n);
  endfunction

  // Reference: an accepted add finishes WORDS edges later; nibble k of the
  // true sum a+b+cin becomes visible after k+1 edges.
  int           m_left = 0;
  int           m_k    = 0;
  logic         m_done = 1'b0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic [W:0]   m_full = '0;
  logic         m_amsb = 1'b0;
  logic         m_bmsb = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_k    <= 0;
      m_done <= 1'b0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_sum  <= '0;
    end else if (m_left > 0) begin
      m_sum  <= (m_sum & ~lowmask(m_k + 1)) | (m_full[W-1:0] & lowmask(m_k + 1));
      m_k    <= m_k + 1;
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_cout <= m_full[W];
        m_ovf  <= (m_amsb == m_bmsb) && (m_full[W-1] != m_amsb);
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_full <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        m_amsb <= a[W-1];
        m_bmsb <= b[W-1];
        m_left <= WORDS;
        m_k    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
`ifdef SIGNED_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    output int lat);
    @(posedge clk); #3;
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("done_seen", lat >= 0, 1'b1);
  endtask

  initial begin
    int lat;
    int n;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_sum", sum, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cout", cout, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    op(16'h1234, 16'h4321, 1'b0, lat);
    chk("basic_latency", lat, 4);
    chk("basic_sum", sum, 16'h5555);
    chk("basic_cout", cout, 1'b0);
    chk("model_basic", m_sum, 16'h5555);

    op(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("ripple_sum", sum, 16'h0000);
    chk("ripple_cout", cout, 1'b1);
    chk("model_ripple", {m_cout, m_sum}, 17'h10000);

    op(16'h00FF, 16'h0000, 1'b1, lat);
    chk("cin_sum", sum, 16'h0100);
    chk("cin_cout", cout, 1'b0);

`ifdef SIGNED_OVF_EN
    op(16'h7FFF, 16'h0001, 1'b0, lat);
    chk("ovf_sum", sum, 16'h8000);
    chk("ovf_set", ovf, 1'b1);
    op(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("ovf_clr", ovf, 1'b0);
    chk("ovf_cout", cout, 1'b1);
`endif

    // second start lands in RUN and must be dropped
    @(posedge clk); #3;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #3;
    a = 16'h1111; b = 16'h1111;
    @(posedge clk); #3;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        n++;
        chk("busy_start_sum", sum, 16'h0002);
      end
    end
    chk("busy_start_dones", n, 1);

    // start held high: restart from the DONE cycle
    @(posedge clk); #3;
    a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) begin
        n++;
        chk("b2b_sum", sum, 16'h0030);
      end
    end
    chk("b2b_dones", n, 3);
    @(posedge clk); #3;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;

    // reset two cycles into RUN
    a = 16'h0F0F; b = 16'h00F1; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_sum", sum, '0);
    chk("abort_busy", busy, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    op(16'h0F0F, 16'h00F1, 1'b0, lat);
    chk("after_abort_sum", sum, 16'h1000);
    chk("after_abort_cout", cout, 1'b0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #3;
      rst_n = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = '1;
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
